amplitude_ramp: RTL and testbench

//  Soft-start/soft-stop amplitude controller that sits directly upstream of the sine PWM generator.

---
 rtl/amplitude_ramp_if.sv | 24 ++
 rtl/amplitude_ramp.sv | 166 ++++++++++++++++
 tb/tb_amplitude_ramp.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/amplitude_ramp_if.sv
// Control/status bundle between a sequencer (master) and the amplitude ramp (slave).
// The slave side produces the amplitude and enable that feed the sine PWM generator.
interface amplitude_ramp_if #(
  parameter int RESOLUTION = 8
);
  logic [RESOLUTION-1:0] target;
  logic                  load;
  logic                  start;
  logic                  stop;
  logic [RESOLUTION-1:0] max_value;
  logic                  enable;
  logic                  busy;
  logic                  done;

  modport master (
    output target, load, start, stop,
    input  max_value, enable, busy, done
  );

  modport slave (
    input  target, load, start, stop,
    output max_value, enable, busy, done
  );
endinterface

// File: rtl/amplitude_ramp.sv
// Soft-start/soft-stop amplitude controller: walks max_value 1 LSB per step tick toward
// the loaded target, holds it, and on stop ramps to 0 before dropping enable.
module amplitude_ramp #(
  parameter int CLK_FREQUENCY  = 10000000,
  parameter int STEP_FREQUENCY = 1000,
  parameter int RESOLUTION     = 8
) (
  input logic               clk,
  input logic               reset,
  amplitude_ramp_if.slave   bus
);

  localparam int DIVIDER = CLK_FREQUENCY / STEP_FREQUENCY;
  localparam int CNT_W   = (DIVIDER > 1) ? $clog2(DIVIDER) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (DIVIDER > 1) ? CNT_W'(DIVIDER - 1) : {CNT_W{1'b0}};
  localparam logic [RESOLUTION-1:0] VAL_ZERO = {RESOLUTION{1'b0}};
  localparam logic [RESOLUTION-1:0] VAL_MAX  = {RESOLUTION{1'b1}};

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RAMP     = 2'd1,
    HOLD     = 2'd2,
    SHUTDOWN = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [RESOLUTION-1:0] max_q, max_d;
  logic [RESOLUTION-1:0] target_q, target_d;
  logic                  enable_q, enable_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  tick_s;
  logic                  start_s;

  function automatic logic [RESOLUTION-1:0] inc_sat(input logic [RESOLUTION-1:0] v);
    logic [RESOLUTION-1:0] r;
    if (v == VAL_MAX) begin
      r = VAL_MAX;
    end else begin
      r = v + {{(RESOLUTION-1){1'b0}}, 1'b1};
    end
    return r;
  endfunction

  function automatic logic [RESOLUTION-1:0] dec_sat(input logic [RESOLUTION-1:0] v);
    logic [RESOLUTION-1:0] r;
    if (v == VAL_ZERO) begin
      r = VAL_ZERO;
    end else begin
      r = v - {{(RESOLUTION-1){1'b0}}, 1'b1};
    end
    return r;
  endfunction

  // A divider of 0 or 1 degenerates to a step on every cycle.
  assign tick_s  = (DIVIDER <= 1) ? 1'b1 : (cnt_q == CNT_LAST);
  assign start_s = bus.start & ~bus.stop;

  // Next-state, amplitude and output decode.
  always_comb begin
    state_d  = state_q;
    max_d    = max_q;
    enable_d = enable_q;
    done_d   = 1'b0;
    if (bus.load) begin
      target_d = bus.target;
    end else begin
      target_d = target_q;
    end

    case (state_q)
      IDLE: begin
        max_d    = VAL_ZERO;
        enable_d = 1'b0;
        if (start_s) begin
          state_d  = RAMP;
          enable_d = 1'b1;
        end else begin
          state_d  = IDLE;
        end
      end
      RAMP: begin
        if (bus.stop) begin
          state_d = SHUTDOWN;
        end else if (max_q == target_q) begin
          state_d = HOLD;
          done_d  = 1'b1;
        end else if (tick_s) begin
          if (max_q < target_q) begin
            max_d = inc_sat(max_q);
          end else begin
            max_d = dec_sat(max_q);
          end
        end else begin
          max_d = max_q;
        end
      end
      HOLD: begin
        if (bus.stop) begin
          state_d = SHUTDOWN;
        end else if (target_q != max_q) begin
          state_d = RAMP;
        end else begin
          state_d = HOLD;
        end
      end
      SHUTDOWN: begin
        // A fresh start resumes from the current amplitude instead of bottoming out.
        if (start_s) begin
          state_d = RAMP;
        end else if (max_q == VAL_ZERO) begin
          state_d  = IDLE;
          enable_d = 1'b0;
        end else if (tick_s) begin
          max_d = dec_sat(max_q);
        end else begin
          max_d = max_q;
        end
      end
      default: begin
        state_d  = IDLE;
        max_d    = VAL_ZERO;
        enable_d = 1'b0;
      end
    endcase

    busy_d = (state_d == RAMP) || (state_d == SHUTDOWN);

    // Restarting the prescaler on entry makes the first step land a full divider later.
    if ((state_d != state_q) || !((state_q == RAMP) || (state_q == SHUTDOWN))) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (tick_s) begin
      cnt_d = {CNT_W{1'b0}};
    end else begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // State, amplitude and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      max_q    <= VAL_ZERO;
      target_q <= VAL_ZERO;
      enable_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      cnt_q    <= {CNT_W{1'b0}};
    end else begin
      state_q  <= state_d;
      max_q    <= max_d;
      target_q <= target_d;
      enable_q <= enable_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.max_value = max_q;
  assign bus.enable    = enable_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_amplitude_ramp.sv
// Directed bench for amplitude_ramp with DIVIDER = 4000/1000 = 4.
// Vectors are applied on the falling edge and outputs are sampled there too.
module tb_amplitude_ramp;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  amplitude_ramp_if #(.RESOLUTION(8)) bus ();

  amplitude_ramp #(
    .CLK_FREQUENCY (4000),
    .STEP_FREQUENCY(1000),
    .RESOLUTION    (8)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    int         cyc;
    logic [7:0] tgt;
    logic       ld;
    logic       st;
    logic       sp;
    logic [7:0] e_max;
    logic       e_en;
    logic       e_busy;
    logic       e_done;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string nm, input int cyc, input logic [7:0] tgt,
                     input logic ld, input logic st, input logic sp,
                     input logic [7:0] e_max, input logic e_en,
                     input logic e_busy, input logic e_done);
    vec_t v;
    v.name = nm; v.cyc = cyc; v.tgt = tgt; v.ld = ld; v.st = st; v.sp = sp;
    v.e_max = e_max; v.e_en = e_en; v.e_busy = e_busy; v.e_done = e_done;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string nm, input logic [7:0] e_max, input logic e_en,
                         input logic e_busy, input logic e_done);
    chk({nm, ".max"},  32'(bus.max_value), 32'(e_max));
    chk({nm, ".en"},   32'(bus.enable),    32'(e_en));
    chk({nm, ".busy"}, 32'(bus.busy),      32'(e_busy));
    chk({nm, ".done"}, 32'(bus.done),      32'(e_done));
  endtask

  task automatic edges(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  // Drive strobes for exactly one rising edge.
  task automatic pulse(input logic [7:0] tgt, input logic ld, input logic st, input logic sp);
    bus.target = tgt;
    bus.load   = ld;
    bus.start  = st;
    bus.stop   = sp;
    edges(1);
    bus.load   = 1'b0;
    bus.start  = 1'b0;
    bus.stop   = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    bus.target = 8'd0;
    bus.load   = 1'b0;
    bus.start  = 1'b0;
    bus.stop   = 1'b0;

    //     name           cyc  tgt      ld    st    sp    max     en    busy  done
    add("s1_load",       1,   8'd5,   1'b1, 1'b0, 1'b0, 8'd0,   1'b0, 1'b0, 1'b0);
    add("s1_start",      1,   8'd5,   1'b0, 1'b1, 1'b0, 8'd0,   1'b1, 1'b1, 1'b0);
    add("s1_e3",         3,   8'd0,   1'b0, 1'b0, 1'b0, 8'd0,   1'b1, 1'b1, 1'b0);
    add("s1_v1",         1,   8'd0,   1'b0, 1'b0, 1'b0, 8'd1,   1'b1, 1'b1, 1'b0);
    add("s1_v2",         4,   8'd0,   1'b0, 1'b0, 1'b0, 8'd2,   1'b1, 1'b1, 1'b0);
    add("s1_v5",         12,  8'd0,   1'b0, 1'b0, 1'b0, 8'd5,   1'b1, 1'b1, 1'b0);
    add("s1_done",       1,   8'd0,   1'b0, 1'b0, 1'b0, 8'd5,   1'b1, 1'b0, 1'b1);
    add("s1_hold",       1,   8'd0,   1'b0, 1'b0, 1'b0, 8'd5,   1'b1, 1'b0, 1'b0);
    add("s2_load",       1,   8'd2,   1'b1, 1'b0, 1'b0, 8'd5,   1'b1, 1'b0, 1'b0);
    add("s2_ramp",       1,   8'd0,   1'b0, 1'b0, 1'b0, 8'd5,   1'b1, 1'b1, 1'b0);
    add("s2_v4",         4,   8'd0,   1'b0, 1'b0, 1'b0, 8'd4,   1'b1, 1'b1, 1'b0);
    add("s2_v2",         8,   8'd0,   1'b0, 1'b0, 1'b0, 8'd2,   1'b1, 1'b1, 1'b0);
    add("s2_done",       1,   8'd0,   1'b0, 1'b0, 1'b0, 8'd2,   1'b1, 1'b0, 1'b1);
    add("s2_once",       3,   8'd0,   1'b0, 1'b0, 1'b0, 8'd2,   1'b1, 1'b0, 1'b0);
    add("s3_load",       1,   8'd5,   1'b1, 1'b0, 1'b0, 8'd2,   1'b1, 1'b0, 1'b0);
    add("s3_ramp",       1,   8'd0,   1'b0, 1'b0, 1'b0, 8'd2,   1'b1, 1'b1, 1'b0);
    add("s3_v3",         4,   8'd0,   1'b0, 1'b0, 1'b0, 8'd3,   1'b1, 1'b1, 1'b0);
    add("s3_v5",         8,   8'd0,   1'b0, 1'b0, 1'b0, 8'd5,   1'b1, 1'b1, 1'b0);
    add("s3_done",       1,   8'd0,   1'b0, 1'b0, 1'b0, 8'd5,   1'b1, 1'b0, 1'b1);
    add("s3_stop",       1,   8'd0,   1'b0, 1'b0, 1'b1, 8'd5,   1'b1, 1'b1, 1'b0);
    add("s3_v4",         4,   8'd0,   1'b0, 1'b0, 1'b0, 8'd4,   1'b1, 1'b1, 1'b0);
    add("s3_v0",         16,  8'd0,   1'b0, 1'b0, 1'b0, 8'd0,   1'b1, 1'b1, 1'b0);
    add("s3_off",        1,   8'd0,   1'b0, 1'b0, 1'b0, 8'd0,   1'b0, 1'b0, 1'b0);
    add("s3_idle",       4,   8'd0,   1'b0, 1'b0, 1'b0, 8'd0,   1'b0, 1'b0, 1'b0);
    add("s5_startstop",  1,   8'd0,   1'b0, 1'b1, 1'b1, 8'd0,   1'b0, 1'b0, 1'b0);
    add("s5_still",      5,   8'd0,   1'b0, 1'b0, 1'b0, 8'd0,   1'b0, 1'b0, 1'b0);
    add("s5_load255",    1,   8'd255, 1'b1, 1'b0, 1'b0, 8'd0,   1'b0, 1'b0, 1'b0);
    add("s5_start",      1,   8'd0,   1'b0, 1'b1, 1'b0, 8'd0,   1'b1, 1'b1, 1'b0);
    add("s5_v254",       1016,8'd0,   1'b0, 1'b0, 1'b0, 8'd254, 1'b1, 1'b1, 1'b0);
    add("s5_v255",       4,   8'd0,   1'b0, 1'b0, 1'b0, 8'd255, 1'b1, 1'b1, 1'b0);
    add("s5_done",       1,   8'd0,   1'b0, 1'b0, 1'b0, 8'd255, 1'b1, 1'b0, 1'b1);
    add("s5_nowrap",     50,  8'd0,   1'b0, 1'b0, 1'b0, 8'd255, 1'b1, 1'b0, 1'b0);

    @(negedge clk);
    @(negedge clk);
    chk_all("reset", 8'd0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;

    foreach (vecs[i]) begin
      pulse(vecs[i].tgt, vecs[i].ld, vecs[i].st, vecs[i].sp);
      edges(vecs[i].cyc - 1);
      chk_all(vecs[i].name, vecs[i].e_max, vecs[i].e_en, vecs[i].e_busy, vecs[i].e_done);
    end

    // Scenario 4: from HOLD at 255, stop, descend to 253, then restart without touching 0.
    pulse(8'd0, 1'b0, 1'b0, 1'b1);
    chk_all("s4_stop", 8'd255, 1'b1, 1'b1, 1'b0);
    edges(8);
    chk_all("s4_down", 8'd253, 1'b1, 1'b1, 1'b0);
    pulse(8'd0, 1'b0, 1'b1, 1'b0);
    chk_all("s4_resume", 8'd253, 1'b1, 1'b1, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      edges(1);
      chk("s4_en", 32'(bus.enable), 32'd1);
      chk("s4_max", 32'(bus.max_value), 32'(253 + k / 4));
    end
    edges(1);
    chk_all("s4_done", 8'd255, 1'b1, 1'b0, 1'b1);

    // Scenario 6: asynchronous reset between edges while ramping.
    pulse(8'd3, 1'b1, 1'b0, 1'b0);
    edges(5);
    chk_all("s6_ramping", 8'd254, 1'b1, 1'b1, 1'b0);
    #2 reset = 1'b1;
    #1 chk_all("s6_async", 8'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    pulse(8'd2, 1'b1, 1'b0, 1'b0);
    chk_all("s6_idle", 8'd0, 1'b0, 1'b0, 1'b0);
    pulse(8'd0, 1'b0, 1'b1, 1'b0);
    chk_all("s6_start", 8'd0, 1'b1, 1'b1, 1'b0);
    edges(4);
    chk_all("s6_v1", 8'd1, 1'b1, 1'b1, 1'b0);
    edges(4);
    chk_all("s6_v2", 8'd2, 1'b1, 1'b1, 1'b0);
    edges(1);
    chk_all("s6_done", 8'd2, 1'b1, 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
